hazard_stall_control: RTL and testbench

Pipeline hazard controller that drives the program counter's write enable and the IF/ID and ID/EX pipeline-register enables and flushes. It detects load-use hazards and holds fetch/decode for a programmable number of cycles. It freezes the whole front end while data memory reports busy and squashes wrong-path instructions on a taken branch. It sits beside the decode stage and is the sole source of `PCWrite` for the program counter.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_stall_control.sv | 110 +++++++++++
 tb/tb_hazard_stall_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the hazard stall controller
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN,
    LD_STALL,
    MEM_WAIT
  } state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detection between ID and EX
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_uses_rs1,
  input  logic                  ID_uses_rs2,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  output logic                  lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = ID_uses_rs1 && (ID_rs1 == EX_rd);
  assign rs2_hit = ID_uses_rs2 && (ID_rs2 == EX_rd);
  // A load into x0 never creates a dependency.
  assign lu      = EX_MemRead && (EX_rd != ZERO_REG) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_stall_control.sv
// rtl/hazard_stall_control.sv - PC / pipeline-register enable and flush control
// for load-use stalls, memory-busy freezes and taken-branch squashes.
module hazard_stall_control
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1,
  input  logic [REG_ADDR_W-1:0] ID_rs2,
  input  logic                  ID_uses_rs1,
  input  logic                  ID_uses_rs2,
  input  logic                  EX_MemRead,
  input  logic [REG_ADDR_W-1:0] EX_rd,
  input  logic                  EX_branch_taken,
  input  logic                  mem_busy,
  output logic                  PCWrite,
  output logic                  IF_ID_Write,
  output logic                  ID_EX_Write,
  output logic                  IF_ID_Flush,
  output logic                  ID_EX_Flush,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [3:0] LCNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] lcnt, lcnt_nxt;
  logic       lu;
  logic       stalling;
  logic       flush_evt;

  load_use_detect u_lu (
    .ID_rs1      (ID_rs1),
    .ID_rs2      (ID_rs2),
    .ID_uses_rs1 (ID_uses_rs1),
    .ID_uses_rs2 (ID_uses_rs2),
    .EX_MemRead  (EX_MemRead),
    .EX_rd       (EX_rd),
    .lu          (lu)
  );

  // Leaving MEM_WAIT behaves like the state we return to, so no idle cycle is lost.
  assign stalling = (state == LD_STALL) || ((state == MEM_WAIT) && (lcnt != 4'd0));

  always_comb begin
    state_nxt   = state;
    lcnt_nxt    = lcnt;
    flush_evt   = 1'b0;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    if (rst) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
    end else if (mem_busy) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      state_nxt   = MEM_WAIT;
    end else if (EX_branch_taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      flush_evt   = 1'b1;
      lcnt_nxt    = 4'd0;
      state_nxt   = RUN;
    end else if (stalling) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      lcnt_nxt    = lcnt - 4'd1;
      state_nxt   = (lcnt == 4'd1) ? RUN : LD_STALL;
    end else if (lu) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        lcnt_nxt  = LCNT_INIT;
        state_nxt = LD_STALL;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      lcnt        <= 4'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
      if (!PCWrite && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush_evt && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_control.sv
// tb/tb_hazard_stall_control.sv - directed self-checking bench for hazard_stall_control
module tb_hazard_stall_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic       ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_branch_taken, mem_busy;

  logic        pc1, ifw1, idw1, iff1, idf1;
  logic        pc2, ifw2, idw2, iff2, idf2;
  logic        pc3, ifw3, idw3, iff3, idf3;
  logic [15:0] sc1, fc1, sc2, fc2, sc3, fc3;
  logic [4:0]  ctl1, ctl2, ctl3;

  int n_checks = 0;
  int n_err    = 0;

  // ctl = {PCWrite, IF_ID_Write, ID_EX_Write, IF_ID_Flush, ID_EX_Flush}
  localparam logic [4:0] C_NORM   = 5'b11100;
  localparam logic [4:0] C_STALL  = 5'b00101;
  localparam logic [4:0] C_BRANCH = 5'b11111;
  localparam logic [4:0] C_FROZEN = 5'b00000;

  assign ctl1 = {pc1, ifw1, idw1, iff1, idf1};
  assign ctl2 = {pc2, ifw2, idw2, iff2, idf2};
  assign ctl3 = {pc3, ifw3, idw3, iff3, idf3};

  always #5 clk = ~clk;

  hazard_stall_control #(.LOAD_STALL_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken),
    .mem_busy(mem_busy), .PCWrite(pc1), .IF_ID_Write(ifw1), .ID_EX_Write(idw1),
    .IF_ID_Flush(iff1), .ID_EX_Flush(idf1), .stall_count(sc1), .flush_count(fc1)
  );

  hazard_stall_control #(.LOAD_STALL_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken),
    .mem_busy(mem_busy), .PCWrite(pc2), .IF_ID_Write(ifw2), .ID_EX_Write(idw2),
    .IF_ID_Flush(iff2), .ID_EX_Flush(idf2), .stall_count(sc2), .flush_count(fc2)
  );

  hazard_stall_control #(.LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
    .EX_MemRead(EX_MemRead), .EX_rd(EX_rd), .EX_branch_taken(EX_branch_taken),
    .mem_busy(mem_busy), .PCWrite(pc3), .IF_ID_Write(ifw3), .ID_EX_Write(idw3),
    .IF_ID_Flush(iff3), .ID_EX_Flush(idf3), .stall_count(sc3), .flush_count(fc3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after a falling edge and are checked 1 ns later.
  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic br, input logic busy);
    @(negedge clk);
    EX_MemRead = mr; EX_rd = rd; ID_rs1 = rs1; ID_uses_rs1 = u1;
    ID_rs2 = rs2; ID_uses_rs2 = u2; EX_branch_taken = br; mem_busy = busy;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic hazard();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    EX_MemRead = 0; EX_rd = 0; ID_rs1 = 0; ID_rs2 = 0;
    ID_uses_rs1 = 0; ID_uses_rs2 = 0; EX_branch_taken = 0; mem_busy = 0;
    @(negedge clk); #1;
    check("reset_ctl", ctl1, C_FROZEN);
    check("reset_stall_cnt", sc1, 16'd0);
    rst = 1'b0;
    #1;
    check("run_ctl", ctl1, C_NORM);

    // Single-cycle load-use stall
    hazard();
    check("lu1_stall", ctl1, C_STALL);
    idle();
    check("lu1_after", ctl1, C_NORM);
    check("lu1_stall_cnt", sc1, 16'd1);
    idle();
    check("lu1_stays_run", ctl1, C_NORM);

    // x0 destination and unused source never stall; used rs2 does
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("zero_reg", ctl1, C_NORM);
    drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    check("unused_rs2", ctl1, C_NORM);
    drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    check("used_rs2", ctl1, C_STALL);
    idle();
    check("used_rs2_cnt", sc1, 16'd2);

    // Three-cycle stall
    pulse_reset();
    hazard();
    check("lu3_c1", ctl3, C_STALL);
    idle();
    check("lu3_c2", ctl3, C_STALL);
    idle();
    check("lu3_c3", ctl3, C_STALL);
    idle();
    check("lu3_done", ctl3, C_NORM);
    check("lu3_stall_cnt", sc3, 16'd3);

    // Branch in the second stall cycle aborts the stall
    pulse_reset();
    hazard();
    check("br_c1", ctl3, C_STALL);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    check("br_flush", ctl3, C_BRANCH);
    idle();
    check("br_run", ctl3, C_NORM);
    check("br_flush_cnt", fc3, 16'd1);
    check("br_stall_cnt", sc3, 16'd1);
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0);
    check("br_over_lu", ctl3, C_BRANCH);
    idle();
    check("br_over_lu_run", ctl3, C_NORM);
    check("br_flush_cnt2", fc3, 16'd2);

    // Memory busy in the middle of a two-cycle stall
    pulse_reset();
    hazard();
    check("mb_c1", ctl2, C_STALL);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      check("mb_frozen", ctl2, C_FROZEN);
    end
    idle();
    check("mb_resume", ctl2, C_STALL);
    idle();
    check("mb_run", ctl2, C_NORM);
    check("mb_stall_cnt", sc2, 16'd6);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    check("mb_over_br", ctl2, C_FROZEN);
    idle();
    check("mb_over_br_fcnt", fc2, 16'd0);
    check("mb_over_br_scnt", sc2, 16'd7);

    // Asynchronous reset mid-stall
    pulse_reset();
    hazard();
    idle();
    check("rst_mid_pre", ctl3, C_STALL);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ctl", ctl3, C_FROZEN);
    check("rst_mid_cnt", sc3, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_no_residual", ctl3, C_NORM);
    idle();
    check("rst_no_residual2", ctl3, C_NORM);
    check("rst_stall_cnt", sc3, 16'd0);

    // Counter saturation
    pulse_reset();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (65541) @(posedge clk);
    @(negedge clk); #1;
    check("sat_ctl", ctl1, C_FROZEN);
    check("sat_stall_cnt", sc1, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
